// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one ALU_16 between two requesters and
// returns each registered result on a shared one-hot response bus.

`ifndef ALU_ADD
`define ALU_ADD 3'd0
`define ALU_SUB 3'd1
`define ALU_AND 3'd2
`define ALU_OR  3'd3
`define ALU_XOR 3'd4
`define ALU_SLL 3'd5
`define ALU_SRL 3'd6
`define ALU_SRA 3'd7
`endif

module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid0,
  input  logic        req_valid1,
  output logic        req_ready0,
  output logic        req_ready1,
  input  logic [2:0]  req_op0,
  input  logic [2:0]  req_op1,
  input  logic [15:0] req_a0,
  input  logic [15:0] req_a1,
  input  logic [15:0] req_b0,
  input  logic [15:0] req_b1,
  output logic [1:0]  rsp_valid,
  input  logic        rsp_ready0,
  input  logic        rsp_ready1,
  output logic [15:0] rsp_data,
  output logic        rsp_z,
  output logic        rsp_v,
  output logic        rsp_n,
  output logic [15:0] ops_done,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, state_next;
  logic        last_grant, gnt_r;
  logic [2:0]  op_r;
  logic [15:0] a_r, b_r;
  logic        accept, gnt_next, rsp_done;
  logic [15:0] alu_out;
  logic        alu_z, alu_v, alu_n;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    req_ready0 = 1'b0;
    req_ready1 = 1'b0;
    accept     = 1'b0;
    gnt_next   = 1'b0;
    rsp_done   = 1'b0;
    unique case (state)
      IDLE: begin
        // A lone requester always wins; under contention the one not granted last wins.
        req_ready0 = !req_valid1 || last_grant;
        req_ready1 = !req_valid0 || !last_grant;
        gnt_next   = req_valid1 && req_ready1;
        accept     = (req_valid0 && req_ready0) || gnt_next;
        if (accept) state_next = EXEC;
      end
      EXEC: state_next = RESP;
      RESP: begin
        rsp_done = gnt_r ? rsp_ready1 : rsp_ready0;
        if (rsp_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: operand registers are reset too; they only feed the ALU, but it keeps the datapath free of X after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      gnt_r      <= 1'b0;
      op_r       <= 3'd0;
      a_r        <= 16'd0;
      b_r        <= 16'd0;
      rsp_valid  <= 2'b00;
      rsp_data   <= 16'd0;
      rsp_z      <= 1'b0;
      rsp_v      <= 1'b0;
      rsp_n      <= 1'b0;
      ops_done   <= 16'd0;
      busy       <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      if (accept) begin
        gnt_r      <= gnt_next;
        last_grant <= gnt_next;
        op_r       <= gnt_next ? req_op1 : req_op0;
        a_r        <= gnt_next ? req_a1  : req_a0;
        b_r        <= gnt_next ? req_b1  : req_b0;
      end
      if (state == EXEC) begin
        rsp_data  <= alu_out;
        rsp_z     <= alu_z;
        rsp_v     <= alu_v;
        rsp_n     <= alu_n;
        rsp_valid <= gnt_r ? 2'b10 : 2'b01;
      end
      if (rsp_done) begin
        rsp_valid <= 2'b00;
        ops_done  <= ops_done + 16'd1;
      end
    end
  end

  ALU_16 u_alu (
    .op      (op_r),
    .a       (a_r),
    .b       (b_r),
    .alu_out (alu_out),
    .z       (alu_z),
    .v       (alu_v),
    .n       (alu_n)
  );

endmodule

// Combinational 16-bit ALU; v flags signed overflow on add/sub only.
module ALU_16 (
  input  logic [2:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] alu_out,
  output logic        z,
  output logic        v,
  output logic        n
);

  always_comb begin
    alu_out = 16'd0;
    v       = 1'b0;
    case (op)
      `ALU_ADD: begin
        alu_out = a + b;
        v       = (a[15] == b[15]) && (alu_out[15] != a[15]);
      end
      `ALU_SUB: begin
        alu_out = a - b;
        v       = (a[15] != b[15]) && (alu_out[15] != a[15]);
      end
      `ALU_AND: alu_out = a & b;
      `ALU_OR:  alu_out = a | b;
      `ALU_XOR: alu_out = a ^ b;
      `ALU_SLL: alu_out = a << b[3:0];
      `ALU_SRL: alu_out = a >> b[3:0];
      `ALU_SRA: alu_out = 16'($signed(a) >>> b[3:0]);
      default:  alu_out = 16'd0;
    endcase
    z = (alu_out == 16'd0);
    n = alu_out[15];
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: reset, backpressure,
// contention, round-robin fairness, wrong-side ready and mid-op reset.
`timescale 1ns/1ps

`ifndef ALU_ADD
`define ALU_ADD 3'd0
`endif
`ifndef ALU_SRA
`define ALU_SRA 3'd7
`endif

module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid0, req_valid1;
  logic        req_ready0, req_ready1;
  logic [2:0]  req_op0, req_op1;
  logic [15:0] req_a0, req_a1, req_b0, req_b1;
  logic [1:0]  rsp_valid;
  logic        rsp_ready0, rsp_ready1;
  logic [15:0] rsp_data;
  logic        rsp_z, rsp_v, rsp_n;
  logic [15:0] ops_done;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid0 (req_valid0),
    .req_valid1 (req_valid1),
    .req_ready0 (req_ready0),
    .req_ready1 (req_ready1),
    .req_op0    (req_op0),
    .req_op1    (req_op1),
    .req_a0     (req_a0),
    .req_a1     (req_a1),
    .req_b0     (req_b0),
    .req_b1     (req_b1),
    .rsp_valid  (rsp_valid),
    .rsp_ready0 (rsp_ready0),
    .rsp_ready1 (rsp_ready1),
    .rsp_data   (rsp_data),
    .rsp_z      (rsp_z),
    .rsp_v      (rsp_v),
    .rsp_n      (rsp_n),
    .ops_done   (ops_done),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  initial begin
    int seen;
    int last_cyc;
    rst = 1'b1;
    req_valid0 = 0; req_valid1 = 0;
    req_op0 = 0; req_op1 = 0;
    req_a0 = 0; req_a1 = 0; req_b0 = 0; req_b1 = 0;
    rsp_ready0 = 0; rsp_ready1 = 0;

    // Reset
    do_reset(2);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_ops_done",  32'(ops_done),  32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    check("rst_rsp_data",  32'(rsp_data),  32'h0);
    check("rst_ready0",    32'(req_ready0), 32'h1);
    check("rst_ready1",    32'(req_ready1), 32'h1);

    // Single op with backpressure: SRA 0xAA00 by 4 = 0xFAA0
    req_valid0 = 1; req_op0 = `ALU_SRA; req_a0 = 16'hAA00; req_b0 = 16'd4;
    tick();                                   // E0 accept
    req_valid0 = 0; req_a0 = 16'h1234;        // arbiter must not depend on post-accept stability
    check("single_busy_exec", 32'(busy), 32'h1);
    check("single_no_rsp_yet", 32'(rsp_valid), 32'h0);
    tick();                                   // E1 capture
    check("single_rsp_valid", 32'(rsp_valid), 32'h1);
    check("single_rsp_data",  32'(rsp_data),  32'hFAA0);
    check("single_rsp_z",     32'(rsp_z),     32'h0);
    check("single_rsp_n",     32'(rsp_n),     32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid_hold", 32'(rsp_valid), 32'h1);
      check("bp_data_hold",  32'(rsp_data),  32'hFAA0);
      check("bp_ops_hold",   32'(ops_done),  32'h0);
    end
    rsp_ready0 = 1;
    tick();
    rsp_ready0 = 0;
    check("single_rsp_clear", 32'(rsp_valid), 32'h0);
    check("single_ops_done",  32'(ops_done),  32'h1);

    // Contention right after reset: requester 0 wins first
    do_reset(1);
    req_valid0 = 1; req_op0 = `ALU_SRA; req_a0 = 16'hFFFF; req_b0 = 16'd1;
    req_valid1 = 1; req_op1 = `ALU_SRA; req_a1 = 16'h00FF; req_b1 = 16'd8;
    rsp_ready0 = 1; rsp_ready1 = 1;
    #1;
    check("cont_ready0", 32'(req_ready0), 32'h1);
    check("cont_ready1", 32'(req_ready1), 32'h0);
    tick();
    req_valid0 = 0;
    tick();
    check("cont_first_valid", 32'(rsp_valid), 32'h1);
    check("cont_first_data",  32'(rsp_data),  32'hFFFF);
    check("cont_stall_ready1", 32'(req_ready1), 32'h0);
    tick();                                   // handshake
    tick();                                   // accept req1
    req_valid1 = 0;
    tick();
    check("cont_second_valid", 32'(rsp_valid), 32'h2);
    check("cont_second_data",  32'(rsp_data),  32'h0000);
    check("cont_second_z",     32'(rsp_z),     32'h1);
    tick();
    check("cont_ops_done", 32'(ops_done), 32'h2);

    // Round-robin fairness: 6 ops, alternating grants, 3-cycle interval
    do_reset(1);
    req_valid0 = 1; req_valid1 = 1;
    seen = 0; last_cyc = -1;
    for (int cyc = 0; cyc < 40 && seen < 6; cyc++) begin
      tick();
      if (rsp_valid != 2'b00) begin
        check("rr_grant", 32'(rsp_valid), (seen % 2 == 0) ? 32'h1 : 32'h2);
        if (last_cyc >= 0) check("rr_interval", 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
        seen++;
      end
    end
    check("rr_completed", 32'(seen), 32'd6);
    tick();                                   // sixth handshake
    req_valid0 = 0; req_valid1 = 0;
    check("rr_ops_done", 32'(ops_done), 32'd6);

    // Wrong-side ready: req1 granted, only rsp_ready0 high. ADD 0x7FFF+1 overflows.
    rsp_ready0 = 1; rsp_ready1 = 0;
    req_valid1 = 1; req_op1 = `ALU_ADD; req_a1 = 16'h7FFF; req_b1 = 16'h0001;
    tick();
    req_valid1 = 0;
    tick();
    check("ws_valid", 32'(rsp_valid), 32'h2);
    check("ws_data",  32'(rsp_data),  32'h8000);
    check("ws_v",     32'(rsp_v),     32'h1);
    repeat (2) tick();
    check("ws_valid_hold", 32'(rsp_valid), 32'h2);
    check("ws_ops_hold",   32'(ops_done),  32'd6);
    rsp_ready1 = 1;
    tick();
    check("ws_ops_done", 32'(ops_done), 32'd7);

    // Reset during EXEC drops the op
    req_valid0 = 1; req_op0 = `ALU_SRA; req_a0 = 16'h8000; req_b0 = 16'd1;
    tick();                                   // accepted, now EXEC
    req_valid0 = 0;
    rst = 1;
    tick();
    rst = 0;
    check("mid_rst_valid", 32'(rsp_valid), 32'h0);
    check("mid_rst_busy",  32'(busy),      32'h0);
    check("mid_rst_ops",   32'(ops_done),  32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("mid_rst_no_rsp", 32'(rsp_valid), 32'h0);
    end
    check("mid_rst_ready0", 32'(req_ready0), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
